// File: rtl/vga_scandoubler.sv
// PAL-to-VGA line doubler: each input line fills one half of a ping-pong buffer
// while the other half is replayed twice at the full clock rate.
module vga_scandoubler #(
   parameter int ADDR_W        = 10,
   parameter int HSYNC_OUT_LEN = 56
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scandbl_en,
   input  logic       scanlines_en,
   input  logic [1:0] r_in,
   input  logic [1:0] g_in,
   input  logic [1:0] b_in,
   input  logic       bright_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [1:0] r_out,
   output logic [1:0] g_out,
   output logic [1:0] b_out,
   output logic       bright_out,
   output logic       hsync_out,
   output logic       vsync_out
);
   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_MAX = '1;
   localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

   logic              ce;
   logic              hsync_prev;
   logic              line_seen;
   logic              bank;
   logic [ADDR_W-1:0] wr_cnt;
   logic [ADDR_W-1:0] line_len;
   logic [ADDR_W-1:0] rd_cnt;
   logic [1:0]        rd_pass;
   logic [6:0]        pix_in;
   logic [6:0]        pix_reg;
   logic [6:0]        rd_data;
   logic [6:0]        dim_data;
   logic              line_start;
   logic              wr_en;
   logic              rd_active;
   logic              act_d;
   logic              hs_d;
   logic              pass1_d;
   logic              vsync_d;

   logic [6:0] mem [0:2*DEPTH-1];

   assign pix_in     = {bright_in, r_in, g_in, b_in};
   assign line_start = ce & hsync_prev & ~hsync_in;
   assign wr_en      = ce && (wr_cnt != CNT_MAX);
   assign rd_active  = (rd_pass < 2'd2) && (line_len != '0);

   // Pixels are written one sample late so address n holds the n-th pixel
   // after the falling hsync, and the sample taken at the next line start
   // completes the old line before the bank flips.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce         <= 1'b0;
         hsync_prev <= 1'b1;
         line_seen  <= 1'b0;
         bank       <= 1'b0;
         wr_cnt     <= '0;
         line_len   <= '0;
         pix_reg    <= '0;
      end else begin
         ce <= ~ce;
         if (ce) begin
            hsync_prev <= hsync_in;
            pix_reg    <= pix_in;
            if (line_start) begin
               line_seen <= 1'b1;
               bank      <= ~bank;
               wr_cnt    <= '0;
               // The partial line captured before the first start is never shown.
               line_len  <= !line_seen ? '0 :
                            (wr_cnt == CNT_MAX) ? CNT_MAX : wr_cnt + CNT_ONE;
            end else if (wr_cnt != CNT_MAX) begin
               wr_cnt <= wr_cnt + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt  <= '0;
         rd_pass <= 2'd2;
      end else if (line_start) begin
         rd_cnt  <= '0;
         rd_pass <= 2'd0;
      end else if (rd_active) begin
         if (rd_cnt == line_len - CNT_ONE) begin
            rd_cnt  <= '0;
            rd_pass <= rd_pass + 2'd1;
         end else begin
            rd_cnt <= rd_cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{bank, wr_cnt}] <= pix_reg;
      end
      rd_data <= mem[{~bank, rd_cnt}];
   end

   // Scanline dimming: each 2-bit component shifted right, bright cleared.
   assign dim_data[6] = 1'b0;
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dim
         assign dim_data[2*gi+1] = 1'b0;
         assign dim_data[2*gi]   = rd_data[2*gi+1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_d   <= 1'b0;
         hs_d    <= 1'b0;
         pass1_d <= 1'b0;
         vsync_d <= 1'b1;
      end else begin
         act_d   <= rd_active;
         hs_d    <= 32'(rd_cnt) < HSYNC_OUT_LEN;
         pass1_d <= (rd_pass == 2'd1);
         vsync_d <= vsync_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {bright_out, r_out, g_out, b_out} <= '0;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         vsync_out <= vsync_d;
         if (scandbl_en) begin
            if (act_d) begin
               {bright_out, r_out, g_out, b_out} <= (scanlines_en && pass1_d) ? dim_data : rd_data;
               hsync_out <= ~hs_d;
            end else begin
               {bright_out, r_out, g_out, b_out} <= '0;
               hsync_out <= 1'b1;
            end
         end else if (ce) begin
            {bright_out, r_out, g_out, b_out} <= pix_in;
            hsync_out <= hsync_in;
         end
      end
   end
endmodule
